nco_sweep_ctrl: RTL and testbench

Phase sequencer for the quarter-wave sine/cosine LUT in the iCESDM excitation path. It runs a phase accumulator whose tuning word steps through a programmed frequency sweep, and drives the LUT phase input. It tracks the LUT's fixed pipeline delay so downstream logic (the SDM and the demodulator) can tell which LUT outputs belong to the sweep. It sits between the register/config logic and the LUT, and owns start/abort/done sequencing of each sweep.

---
 rtl/nco_sweep_ctrl_pkg.sv | 14 +
 rtl/valid_delay_line.sv | 44 ++++
 rtl/nco_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared types and constants for the NCO sweep sequencer.
// The default LUT latency must match the sine/cosine LUT instantiation.
package nco_sweep_ctrl_pkg;

    localparam int unsigned LUT_LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Depth x width shift register with strobe enable, synchronous clear
// and asynchronous active-low reset.
module valid_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 13
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    always_comb begin
        pipe_d = pipe_q;
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_d[i] = '0;
            end
        end else if (i_en) begin
            pipe_d[0] = i_data;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_data = pipe_q[DEPTH-1];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Phase sequencer for the quarter-wave LUT: stepped-frequency sweep,
// LUT-latency-aligned valid/step tagging and start/abort/done control.
module nco_sweep_ctrl
    import nco_sweep_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = 24,
    parameter int I_WIDTH     = 13,
    parameter int LUT_LATENCY = LUT_LATENCY_DEF,
    parameter int DWELL_WIDTH = 16,
    parameter int STEP_WIDTH  = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [PHASE_WIDTH-1:0] i_ftw_start,
    input  logic [PHASE_WIDTH-1:0] i_ftw_step,
    input  logic [STEP_WIDTH-1:0]  i_n_steps,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic [I_WIDTH-1:0]     o_phase,
    output logic                   o_valid,
    output logic [STEP_WIDTH-1:0]  o_step_idx,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int FLUSH_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
    localparam logic [FLUSH_W-1:0]     FLUSH_LAST = FLUSH_W'(LUT_LATENCY - 1);
    localparam logic [FLUSH_W-1:0]     FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [STEP_WIDTH-1:0]  STEP_ONE   = STEP_WIDTH'(1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE  = DWELL_WIDTH'(1);

    state_e                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] ftw_q, ftw_d;
    logic [PHASE_WIDTH-1:0] ftw_step_q, ftw_step_d;
    logic [STEP_WIDTH-1:0]  n_steps_q, n_steps_d;
    logic [STEP_WIDTH-1:0]  step_q, step_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;

    logic                   issued;
    logic [DWELL_WIDTH-1:0] dwell_in;
    logic [STEP_WIDTH:0]    pipe_in;
    logic [STEP_WIDTH:0]    pipe_out;

    // A zero dwell would never reach the step boundary, so it runs as 1.
    assign dwell_in = (i_dwell == '0) ? DWELL_ONE : i_dwell;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ftw_d       = ftw_q;
        ftw_step_d  = ftw_step_q;
        n_steps_d   = n_steps_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        ftw_step_d  = i_ftw_step;
                        n_steps_d   = i_n_steps;
                        dwell_d     = dwell_in;
                        acc_d       = '0;
                        ftw_d       = i_ftw_start;
                        step_d      = '0;
                        dwell_cnt_d = dwell_in;
                        state_d     = (i_n_steps == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_en) begin
                        acc_d       = acc_q + ftw_q;
                        dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
                        if (dwell_cnt_q == DWELL_ONE) begin
                            if (step_q == n_steps_q - STEP_ONE) begin
                                state_d     = ST_FLUSH;
                                flush_cnt_d = '0;
                            end else begin
                                ftw_d       = ftw_q + ftw_step_q;
                                step_d      = step_q + STEP_ONE;
                                dwell_cnt_d = dwell_q;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    if (i_en) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            flush_cnt_d = flush_cnt_q + FLUSH_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            ftw_q       <= '0;
            ftw_step_q  <= '0;
            n_steps_q   <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ftw_q       <= ftw_d;
            ftw_step_q  <= ftw_step_d;
            n_steps_q   <= n_steps_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Sample tag travels alongside the LUT pipeline, one stage per strobe.
    assign issued  = (state_q == ST_RUN) && i_en;
    assign pipe_in = {issued, step_q};

    valid_delay_line #(
        .DEPTH (LUT_LATENCY),
        .WIDTH (STEP_WIDTH + 1)
    ) u_valid_dl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_abort),
        .i_data  (pipe_in),
        .o_data  (pipe_out)
    );

    assign o_phase    = acc_q[PHASE_WIDTH-1 -: I_WIDTH];
    assign o_valid    = pipe_out[STEP_WIDTH];
    assign o_step_idx = pipe_out[STEP_WIDTH-1:0];
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed and randomized sweeps
// scored against a list-of-samples reference and a bench-side LUT delay.
module tb_nco_sweep_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] ftw_start = '0;
    logic [23:0] ftw_step = '0;
    logic [11:0] n_steps = '0;
    logic [15:0] dwell = '0;
    logic [12:0] o_phase;
    logic        o_valid;
    logic [11:0] o_step_idx;
    logic        o_busy;
    logic        o_done;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [12:0] hist[$];
    logic [12:0] exp_ph[$];
    logic [11:0] exp_st[$];
    int          exp_total;

    nco_sweep_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_start     (start),
        .i_abort     (abort),
        .i_ftw_start (ftw_start),
        .i_ftw_step  (ftw_step),
        .i_n_steps   (n_steps),
        .i_dwell     (dwell),
        .o_phase     (o_phase),
        .o_valid     (o_valid),
        .o_step_idx  (o_step_idx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, got, exp, cyc);
        end
    endtask

    // One clock; the LUT model latches the phase on every enabled edge.
    task automatic tick(input logic e);
        en = e;
        if (e) begin
            hist.push_back(o_phase);
            if (hist.size() > LAT) void'(hist.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic pick(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 4) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected sample list: per step, dwell samples whose phase is the
    // running sum of earlier tuning words, top 13 bits of a 24-bit sum.
    task automatic build(input logic [23:0] fs, input logic [23:0] fst,
                         input int n, input int d);
        logic [23:0] acc;
        logic [23:0] f;
        int          de;
        exp_ph.delete();
        exp_st.delete();
        de  = (d == 0) ? 1 : d;
        acc = '0;
        f   = fs;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < de; k++) begin
                exp_ph.push_back(acc[23:11]);
                exp_st.push_back(12'(s));
                acc = acc + f;
            end
            f = f + fst;
        end
        exp_total = n * de;
    endtask

    task automatic run_sweep(input logic [23:0] fs, input logic [23:0] fst,
                             input int n, input int d, input int mode,
                             input int abort_at);
        int   en_edges = 0;
        int   got_valid = 0;
        int   last_vcyc = -1;
        logic fin = 1'b0;
        logic e;
        logic pv;
        logic [11:0] ps;
        build(fs, fst, n, d);
        ftw_start = fs;
        ftw_step  = fst;
        n_steps   = 12'(n);
        dwell     = 16'(d);
        pv = o_valid;
        ps = o_step_idx;
        for (int t = 0; t < 3000 && !fin; t++) begin
            if (t == 0) start = 1'b1;
            if (abort_at >= 0 && en_edges >= abort_at) abort = 1'b1;
            e = pick(mode);
            tick(e);
            start = 1'b0;
            ftw_start = 24'($urandom);
            n_steps   = 12'($urandom);
            dwell     = 16'($urandom);
            if (t == 0) chk("busy_rise", o_busy, 1);
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", o_valid, 0);
                chk("abort_busy", o_busy, 0);
                chk("abort_done", o_done, 0);
                for (int k = 0; k < 6; k++) begin
                    tick(1'b1);
                    chk("abort_no_done", o_done, 0);
                    chk("abort_idle", o_busy, 0);
                end
                fin = 1'b1;
            end else begin
                if (e) en_edges++;
                if (!e) begin
                    chk("hold_valid", o_valid, pv);
                    chk("hold_step", o_step_idx, ps);
                end else if (o_valid) begin
                    got_valid++;
                    last_vcyc = cyc;
                    if (exp_ph.size() > 0 && hist.size() == LAT) begin
                        chk("phase", hist[0], exp_ph[0]);
                        chk("step_idx", o_step_idx, exp_st[0]);
                        void'(exp_ph.pop_front());
                        void'(exp_st.pop_front());
                    end
                end
                pv = o_valid;
                ps = o_step_idx;
                if (o_done) begin
                    chk("valid_count", got_valid, exp_total);
                    chk("done_after_valid", cyc > last_vcyc, 1);
                    if (mode == 0 && n > 0) chk("done_lat", cyc - last_vcyc, 1);
                    tick(1'(pick(mode)));
                    chk("busy_fall", o_busy, 0);
                    chk("done_pulse", o_done, 0);
                    fin = 1'b1;
                end
            end
        end
        chk("sweep_finished", fin, 1);
    endtask

    initial begin
        #2;
        chk("rst_phase", o_phase, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_step", o_step_idx, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b1);

        // basic, strobed, boundaries, wrap
        run_sweep(24'h010000, 24'h010000, 3, 4, 0, -1);
        run_sweep(24'h010000, 24'h010000, 3, 4, 1, -1);
        run_sweep(24'h123456, 24'h000100, 0, 4, 0, -1);
        run_sweep(24'h0A0000, 24'h001000, 3, 0, 0, -1);
        run_sweep(24'h0A0000, 24'h001000, 3, 1, 0, -1);
        run_sweep(24'hFFFFFF, 24'hFFFFFF, 2, 3, 0, -1);

        // abort mid-run, then a clean sweep from phase 0
        run_sweep(24'h010000, 24'h010000, 3, 4, 0, 5);
        run_sweep(24'h030000, 24'h008000, 2, 2, 0, -1);

        for (int r = 0; r < 8; r++) begin
            run_sweep(24'($urandom), 24'($urandom), $urandom_range(0, 4),
                      $urandom_range(0, 5), $urandom_range(0, 2), -1);
        end

        // asynchronous reset while flushing
        ftw_start = 24'h100000;
        ftw_step  = 24'h000000;
        n_steps   = 12'd1;
        dwell     = 16'd2;
        start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        tick(1'b1);
        tick(1'b1);
        chk("pre_rst_busy", o_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_phase", o_phase, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_step", o_step_idx, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_done", o_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1'b1);
            chk("post_rst_done", o_done, 0);
            chk("post_rst_busy", o_busy, 0);
        end
        run_sweep(24'h010000, 24'h010000, 3, 4, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
